// File: rtl/reg_enable_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// reg_seq_pkg
// Shared definitions for the register write-enable sequencer:
//   - state_t      : sequencer FSM states (IDLE, DRIVE)
//   - ST_IDLE/ST_DRIVE : the same encodings as plain logic constants, used for
//                    the state register itself
//   - RST_*        : reset values of the single-bit registered outputs
// No ports (package).
// ---------------------------------------------------------------------------
package reg_seq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_DRIVE = DRIVE;

    localparam logic RST_BUSY = 1'b0;
    localparam logic RST_ERR  = 1'b0;

endpackage : reg_seq_pkg

// File: rtl/reg_enable_sequencer_if.sv
// ---------------------------------------------------------------------------
// reg_enable_sequencer_if
// Bundles the request handshake and the register-file side outputs of the
// sequencer.
//   req_valid  : request present                       (master -> slave)
//   req_num    : register number, unsigned             (master -> slave)
//   req_ready  : sequencer can accept this cycle       (slave -> master)
//   reg_enable : registered one-hot write enable       (slave -> master)
//   busy       : sequencer is driving an enable        (slave -> master)
//   err        : one-cycle out-of-range pulse          (slave -> master)
//   err_count  : saturating out-of-range count         (slave -> master)
// Modports: master (decode side / bench), slave (sequencer).
// ---------------------------------------------------------------------------
interface reg_enable_sequencer_if
    import reg_seq_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int NUM_W    = 16,
    parameter int ERR_W    = 8
);
    logic                req_valid;
    logic [NUM_W-1:0]    req_num;
    logic                req_ready;
    logic [NUM_REGS-1:0] reg_enable;
    logic                busy;
    logic                err;
    logic [ERR_W-1:0]    err_count;

    modport master (
        output req_valid,
        output req_num,
        input  req_ready,
        input  reg_enable,
        input  busy,
        input  err,
        input  err_count
    );

    modport slave (
        input  req_valid,
        input  req_num,
        output req_ready,
        output reg_enable,
        output busy,
        output err,
        output err_count
    );
endinterface : reg_enable_sequencer_if

// File: rtl/reg_enable_sequencer_decoder.sv
// ---------------------------------------------------------------------------
// onehot_msb_decoder
// Combinational register-number decoder. Register 0 maps to the MSB of the
// one-hot vector, register NUM_REGS-1 to bit 0.
//   num      in  NUM_W     : register number, unsigned
//   onehot   out NUM_REGS  : one-hot enable, all zero when out of range
//   in_range out 1         : num < NUM_REGS over the full NUM_W bits
// ---------------------------------------------------------------------------
module onehot_msb_decoder
    import reg_seq_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int NUM_W    = 16
) (
    input  logic [NUM_W-1:0]    num,
    output logic [NUM_REGS-1:0] onehot,
    output logic                in_range
);
    // NUM_REGS may not fit in NUM_W bits (e.g. 32 registers, 5-bit number),
    // so compare in a width wide enough for both operands.
    localparam int CMP_W = (NUM_W > 32) ? NUM_W : 32;

    logic [CMP_W-1:0] num_ext;

    assign num_ext  = CMP_W'(num);
    assign in_range = (num_ext < CMP_W'(NUM_REGS));

    // Each bit matches exactly one register index, so an out-of-range number
    // (including one with stray upper bits) yields all zeros naturally.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
        assign onehot[NUM_REGS-1-gi] = (num_ext == CMP_W'(gi));
    end
endmodule : onehot_msb_decoder

// File: rtl/reg_enable_sequencer.sv
// ---------------------------------------------------------------------------
// reg_enable_sequencer
// Accepts a register number over a valid/ready handshake and drives a
// registered one-hot write enable for HOLD_CYCLES cycles. Out-of-range
// numbers produce a one-cycle err pulse and bump a saturating counter.
//   clk  in  : clock, rising edge
//   rst  in  : synchronous active-high reset
//   bus  slave modport of reg_enable_sequencer_if:
//        req_valid/req_num in, req_ready (combinational, state only),
//        reg_enable/busy/err/err_count (all registered) out
// ---------------------------------------------------------------------------
module reg_enable_sequencer
    import reg_seq_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int NUM_W       = 16,
    parameter int HOLD_CYCLES = 1,
    parameter int ERR_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    reg_enable_sequencer_if.slave        bus
);
    // One spare bit keeps the counter at least 1 bit wide when HOLD_CYCLES=1.
    localparam int              HC_W      = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    logic [0:0]          state_reg,  state_next;
    logic [HC_W-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [NUM_REGS-1:0] enable_reg, enable_next;
    logic                busy_reg,   busy_next;
    logic                err_reg,    err_next;
    logic [ERR_W-1:0]    err_cnt_reg, err_cnt_next;

    logic [NUM_REGS-1:0] dec_onehot;
    logic                dec_in_range;
    logic                last_cycle;
    logic                ready;
    logic                accept;

    onehot_msb_decoder #(
        .NUM_REGS (NUM_REGS),
        .NUM_W    (NUM_W)
    ) u_dec (
        .num      (bus.req_num),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    assign last_cycle = (hold_cnt_reg == HOLD_LAST);
    assign ready      = (state_reg == ST_IDLE) ||
                        ((state_reg == ST_DRIVE) && last_cycle);
    assign accept     = bus.req_valid && ready;

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        enable_next   = enable_reg;
        err_next      = 1'b0;
        err_cnt_next  = err_cnt_reg;

        if (accept) begin
            // Same handling from IDLE and from the last DRIVE cycle, which
            // gives back-to-back enables with no zero gap.
            hold_cnt_next = '0;
            if (dec_in_range) begin
                state_next  = ST_DRIVE;
                enable_next = dec_onehot;
            end else begin
                state_next  = ST_IDLE;
                enable_next = '0;
                err_next    = 1'b1;
                if (err_cnt_reg != {ERR_W{1'b1}}) begin
                    err_cnt_next = err_cnt_reg + ERR_W'(1);
                end
            end
        end else if (state_reg == ST_DRIVE) begin
            if (last_cycle) begin
                state_next    = ST_IDLE;
                enable_next   = '0;
                hold_cnt_next = '0;
            end else begin
                hold_cnt_next = hold_cnt_reg + HC_W'(1);
            end
        end

        // busy is registered alongside the enable so it matches it exactly.
        busy_next = (state_next == ST_DRIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            enable_reg   <= '0;
            busy_reg     <= RST_BUSY;
            err_reg      <= RST_ERR;
            err_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            enable_reg   <= enable_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
            err_cnt_reg  <= err_cnt_next;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.reg_enable = enable_reg;
    assign bus.busy       = busy_reg;
    assign bus.err        = err_reg;
    assign bus.err_count  = err_cnt_reg;
endmodule : reg_enable_sequencer

// File: tb/tb_reg_enable_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_enable_sequencer
// Directed bench for reg_enable_sequencer with four configurations:
//   a: defaults (HOLD_CYCLES=1)            - vector table, range errors
//   b: HOLD_CYCLES=3                       - back-to-back hold sequence
//   c: HOLD_CYCLES=4, ERR_W=2              - counter saturation, mid-DRIVE reset
//   d: NUM_REGS=32, NUM_W=5                - full index sweep
// ---------------------------------------------------------------------------
module tb_reg_enable_sequencer;
    import reg_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_c = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    reg_enable_sequencer_if #(.NUM_REGS(8),  .NUM_W(16), .ERR_W(8)) if_a ();
    reg_enable_sequencer_if #(.NUM_REGS(8),  .NUM_W(16), .ERR_W(8)) if_b ();
    reg_enable_sequencer_if #(.NUM_REGS(8),  .NUM_W(16), .ERR_W(2)) if_c ();
    reg_enable_sequencer_if #(.NUM_REGS(32), .NUM_W(5),  .ERR_W(8)) if_d ();

    reg_enable_sequencer #(.NUM_REGS(8), .NUM_W(16), .HOLD_CYCLES(1), .ERR_W(8))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    reg_enable_sequencer #(.NUM_REGS(8), .NUM_W(16), .HOLD_CYCLES(3), .ERR_W(8))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    reg_enable_sequencer #(.NUM_REGS(8), .NUM_W(16), .HOLD_CYCLES(4), .ERR_W(2))
        dut_c (.clk(clk), .rst(rst_c), .bus(if_c));
    reg_enable_sequencer #(.NUM_REGS(32), .NUM_W(5), .HOLD_CYCLES(1), .ERR_W(8))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));

    typedef struct {
        logic        valid;
        logic [15:0] num;
        logic [7:0]  en;
        logic        busy;
        logic        err;
        logic [7:0]  cnt;
        logic        ready;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on every cycle once reset is done.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("onehot_a", 64'($onehot0(if_a.reg_enable)), 64'd1);
            chk("onehot_b", 64'($onehot0(if_b.reg_enable)), 64'd1);
            chk("onehot_c", 64'($onehot0(if_c.reg_enable)), 64'd1);
            chk("onehot_d", 64'($onehot0(if_d.reg_enable)), 64'd1);
            chk("busy_a", 64'(if_a.busy), 64'(if_a.reg_enable != '0));
            chk("busy_b", 64'(if_b.busy), 64'(if_b.reg_enable != '0));
            chk("busy_c", 64'(if_c.busy), 64'(if_c.reg_enable != '0));
            chk("busy_d", 64'(if_d.busy), 64'(if_d.reg_enable != '0));
        end
    end

    initial begin
        // valid, num, en, busy, err, cnt, ready (outputs after the edge)
        vecs[0]  = '{1'b1, 16'd3,      8'b0001_0000, 1'b1, 1'b0, 8'd0, 1'b1};
        vecs[1]  = '{1'b0, 16'd0,      8'b0000_0000, 1'b0, 1'b0, 8'd0, 1'b1};
        vecs[2]  = '{1'b1, 16'h0008,   8'b0000_0000, 1'b0, 1'b1, 8'd1, 1'b1};
        vecs[3]  = '{1'b1, 16'hFFFF,   8'b0000_0000, 1'b0, 1'b1, 8'd2, 1'b1};
        vecs[4]  = '{1'b0, 16'd0,      8'b0000_0000, 1'b0, 1'b0, 8'd2, 1'b1};
        vecs[5]  = '{1'b1, 16'd0,      8'b1000_0000, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[6]  = '{1'b1, 16'd7,      8'b0000_0001, 1'b1, 1'b0, 8'd2, 1'b1};
        vecs[7]  = '{1'b1, 16'd9,      8'b0000_0000, 1'b0, 1'b1, 8'd3, 1'b1};
        vecs[8]  = '{1'b1, 16'd5,      8'b0000_0100, 1'b1, 1'b0, 8'd3, 1'b1};
        vecs[9]  = '{1'b0, 16'd0,      8'b0000_0000, 1'b0, 1'b0, 8'd3, 1'b1};
        vecs[10] = '{1'b1, 16'h0103,   8'b0000_0000, 1'b0, 1'b1, 8'd4, 1'b1};
        vecs[11] = '{1'b0, 16'd0,      8'b0000_0000, 1'b0, 1'b0, 8'd4, 1'b1};

        if_a.req_valid = 1'b0; if_a.req_num = '0;
        if_b.req_valid = 1'b0; if_b.req_num = '0;
        if_c.req_valid = 1'b0; if_c.req_num = '0;
        if_d.req_valid = 1'b0; if_d.req_num = '0;

        // Reset, with a request present that must be dropped.
        if_a.req_valid = 1'b1; if_a.req_num = 16'd2;
        repeat (3) step();
        chk("rst_en_a", 64'(if_a.reg_enable), 64'd0);
        chk("rst_err_a", 64'(if_a.err), 64'd0);
        chk("rst_cnt_a", 64'(if_a.err_count), 64'd0);
        chk("rst_busy_a", 64'(if_a.busy), 64'd0);
        if_a.req_valid = 1'b0;
        rst = 1'b0; rst_c = 1'b0;
        step();
        chk("rel_ready_a", 64'(if_a.req_ready), 64'd1);
        chk("rel_ready_b", 64'(if_b.req_ready), 64'd1);
        chk("rel_en_a", 64'(if_a.reg_enable), 64'd0);
        chk("rel_cnt_c", 64'(if_c.err_count), 64'd0);
        chk_on = 1'b1;

        // ---- a: vector table ----
        for (int i = 0; i < 12; i++) begin
            if_a.req_valid = vecs[i].valid;
            if_a.req_num   = vecs[i].num;
            step();
            $display("a[%0d] valid=%0b num=0x%0h -> en=%b busy=%0b err=%0b cnt=%0d ready=%0b",
                     i, vecs[i].valid, vecs[i].num, if_a.reg_enable, if_a.busy,
                     if_a.err, if_a.err_count, if_a.req_ready);
            chk($sformatf("a%0d_en", i),    64'(if_a.reg_enable), 64'(vecs[i].en));
            chk($sformatf("a%0d_busy", i),  64'(if_a.busy),       64'(vecs[i].busy));
            chk($sformatf("a%0d_err", i),   64'(if_a.err),        64'(vecs[i].err));
            chk($sformatf("a%0d_cnt", i),   64'(if_a.err_count),  64'(vecs[i].cnt));
            chk($sformatf("a%0d_ready", i), 64'(if_a.req_ready),  64'(vecs[i].ready));
        end

        // ---- b: HOLD_CYCLES=3, 0 then 7 accepted on the last hold cycle ----
        if_b.req_valid = 1'b1; if_b.req_num = 16'd0;
        step();
        $display("b: accept 0 -> en=%b ready=%0b", if_b.reg_enable, if_b.req_ready);
        chk("b_h0_en", 64'(if_b.reg_enable), 64'h80);
        chk("b_h0_ready", 64'(if_b.req_ready), 64'd0);
        if_b.req_num = 16'd7;        // held while not ready
        step();
        chk("b_h1_en", 64'(if_b.reg_enable), 64'h80);
        chk("b_h1_ready", 64'(if_b.req_ready), 64'd0);
        step();
        chk("b_h2_en", 64'(if_b.reg_enable), 64'h80);
        chk("b_h2_ready", 64'(if_b.req_ready), 64'd1);
        step();
        $display("b: accept 7 -> en=%b ready=%0b", if_b.reg_enable, if_b.req_ready);
        chk("b_n0_en", 64'(if_b.reg_enable), 64'h01);
        chk("b_n0_ready", 64'(if_b.req_ready), 64'd0);
        if_b.req_valid = 1'b0;
        step();
        chk("b_n1_en", 64'(if_b.reg_enable), 64'h01);
        chk("b_n1_ready", 64'(if_b.req_ready), 64'd0);
        step();
        chk("b_n2_en", 64'(if_b.reg_enable), 64'h01);
        chk("b_n2_ready", 64'(if_b.req_ready), 64'd1);
        step();
        chk("b_end_en", 64'(if_b.reg_enable), 64'h00);
        chk("b_end_ready", 64'(if_b.req_ready), 64'd1);

        // ---- c: ERR_W=2 saturation over five out-of-range requests ----
        if_c.req_valid = 1'b1; if_c.req_num = 16'd8;
        for (int i = 0; i < 5; i++) begin
            step();
            $display("c: bad req %0d -> err=%0b cnt=%0d", i, if_c.err, if_c.err_count);
            chk($sformatf("c_err%0d", i), 64'(if_c.err), 64'd1);
            chk($sformatf("c_cnt%0d", i), 64'(if_c.err_count), 64'((i < 3) ? i + 1 : 3));
            chk($sformatf("c_en%0d", i),  64'(if_c.reg_enable), 64'd0);
        end
        if_c.req_valid = 1'b0;
        step();
        chk("c_err_drop", 64'(if_c.err), 64'd0);
        chk("c_cnt_hold", 64'(if_c.err_count), 64'd3);

        // ---- c: HOLD_CYCLES=4, reset on the second DRIVE cycle ----
        if_c.req_valid = 1'b1; if_c.req_num = 16'd2;
        step();
        if_c.req_valid = 1'b0;
        chk("c_d1_en", 64'(if_c.reg_enable), 64'b0010_0000);
        chk("c_d1_ready", 64'(if_c.req_ready), 64'd0);
        step();
        chk("c_d2_en", 64'(if_c.reg_enable), 64'b0010_0000);
        rst_c = 1'b1;
        step();
        $display("c: reset mid-drive -> en=%b busy=%0b", if_c.reg_enable, if_c.busy);
        chk("c_rst_en", 64'(if_c.reg_enable), 64'd0);
        chk("c_rst_busy", 64'(if_c.busy), 64'd0);
        chk("c_rst_cnt", 64'(if_c.err_count), 64'd0);
        if_c.req_valid = 1'b1; if_c.req_num = 16'd1;   // dropped by reset
        step();
        chk("c_rst_drop_en", 64'(if_c.reg_enable), 64'd0);
        if_c.req_valid = 1'b0;
        rst_c = 1'b0;
        step();
        chk("c_rel_ready", 64'(if_c.req_ready), 64'd1);
        chk("c_rel_en", 64'(if_c.reg_enable), 64'd0);

        // ---- d: NUM_REGS=32 sweep, back-to-back ----
        for (int n = 0; n < 32; n++) begin
            logic [31:0] exp_en;
            exp_en = 32'h8000_0000 >> n;
            if_d.req_valid = 1'b1;
            if_d.req_num   = 5'(n);
            step();
            $display("d: num=%0d -> en=0x%08h", n, if_d.reg_enable);
            chk($sformatf("d_en%0d", n), 64'(if_d.reg_enable), 64'(exp_en));
            chk($sformatf("d_err%0d", n), 64'(if_d.err), 64'd0);
        end
        if_d.req_valid = 1'b0;
        step();
        chk("d_end_en", 64'(if_d.reg_enable), 64'd0);
        chk("d_end_cnt", 64'(if_d.err_count), 64'd0);

        step();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule : tb_reg_enable_sequencer

// File: doc/reg_enable_sequencer.md
# reg_enable_sequencer

Parametrised successor to the processor's register-number decoder. Accepts a register number over a valid/ready handshake, checks its range, and drives a registered one-hot write enable onto the register file for a programmable number of cycles. Out-of-range requests raise a one-cycle error pulse and increment a saturating error counter. Sits between instruction decode and the register file write port.

## Interface
Parameters:
- NUM_REGS, 8: number of registers; one enable bit per register; must be ≥2.
- NUM_W, 16: width of the register-number input.
- HOLD_CYCLES, 1: cycles each enable stays asserted; must be ≥1.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- req_valid  in  1: request present.
- req_num  in  NUM_W: register number, unsigned.
- req_ready  out  1: block can accept a request this cycle.
- reg_enable  out  NUM_REGS: registered one-hot enable. Register 0 maps to bit NUM_REGS-1 (MSB); register NUM_REGS-1 maps to bit 0.
- busy  out  1: high in DRIVE.
- err  out  1: one-cycle pulse for an out-of-range request.
- err_count  out  ERR_W: number of out-of-range requests, saturating.

## Operation
- Handshake: a request is accepted when req_valid && req_ready. While req_valid is high and req_ready is low, req_num may change; only the value on the accept cycle matters.
- In range: req_num < NUM_REGS. The comparison uses the full NUM_W bits, so upper bits must be zero.
- States:
  - IDLE: reg_enable = 0.
    - In-range accept → DRIVE, hold_cnt ← 0.
    - Out-of-range accept → stay in IDLE, err pulses, err_count increments.
  - DRIVE: reg_enable holds the latched one-hot value and hold_cnt increments.
    - When hold_cnt == HOLD_CYCLES-1 with no accept → IDLE.
    - Accept on the last cycle (back-to-back):
      - in range: re-enter DRIVE with the new one-hot, hold_cnt ← 0, no zero gap;
      - out of range: → IDLE with err.
- req_ready = (state == IDLE) || (state == DRIVE && hold_cnt == HOLD_CYCLES-1).
- err_count saturates at 2^ERR_W − 1. err still pulses when the counter is saturated.
- Reset: state = IDLE, reg_enable = 0, busy = 0, err = 0, err_count = 0, hold_cnt = 0. req_ready is 1 in the cycle after reset is released.
- Reset asserted mid-DRIVE: reg_enable reads 0 in the cycle after the reset edge. A request accepted in the same cycle as reset is dropped.
- At most one bit of reg_enable is ever set.

## Timing
- Latency: accept at edge N → reg_enable valid from cycle N+1 through N+HOLD_CYCLES.
- err asserts in cycle N+1 for one cycle. err_count shows the new value in N+1.
- busy equals (reg_enable != 0) at all times.
- Throughput:
  - One in-range request per HOLD_CYCLES cycles with back-to-back accepts.
  - Out-of-range requests can be accepted every cycle from IDLE.
- All outputs are registered except req_ready, which is a combinational function of state only (never of req_valid).

## Structure
- Package reg_seq_pkg: state enum {IDLE, DRIVE} and the reset-value constants.
- Sub-module onehot_msb_decoder, parametrised by NUM_REGS and NUM_W. It is combinational and produces the one-hot vector plus an in_range flag. The sequencer registers its output.
- hold_cnt width is $clog2(HOLD_CYCLES)+1. This keeps HOLD_CYCLES=1 legal.

## Test plan
1. Defaults; accept req_num=3 → reg_enable=8'b00010000 for exactly 1 cycle starting the next cycle, then 0. busy tracks reg_enable.
2. HOLD_CYCLES=3; accept 0, then 7 on the last hold cycle → 8'b10000000 for 3 cycles, then 8'b00000001 for 3 cycles with no gap. req_ready is low during the first two cycles of each hold.
3. Accept req_num=16'h0008 and 16'hFFFF → reg_enable stays 0, err pulses twice, err_count=2.
4. ERR_W=2; five out-of-range requests → err_count reads 1, 2, 3, 3, 3; err pulses all five times.
5. HOLD_CYCLES=4; assert rst on the second DRIVE cycle → reg_enable=0, busy=0, req_ready=1 after release.
6. NUM_REGS=32, NUM_W=5; sweep 0..31 → each produces exactly bit 31−n, and the one-hot check passes every cycle.
